branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Parametrised branch predictor for the fetch stage: pattern history table (PHT) of
//  CTR_W-bit saturating counters, optional gshare indexing via a global history register,
//  and a tagged branch target buffer (BTB). Fetch looks up pred_pc_i combinationally.
//  Execute resolves branches through the update port. Generalises the 2-bit branch_pred_t
//  scheme to any counter width, depth and history length. Adds a sequential table-init FSM.
// PARAMETERS
//  ENTRIES  64  PHT/BTB depth; power of 2, >=2; IDX_W = $clog2(ENTRIES)
//  CTR_W    2   counter width, 1..4; CTR_W=2 encodes exactly as branch_pred_t
//  TAG_W    8   BTB tag width, taken from pc[TAG_W+IDX_W+1 : IDX_W+2]
//  GHR_W    0   global history bits, 0..IDX_W; 0 = pure bimodal
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset; synchronous, active-high
//  flush_i        in   1       pulse: clear all tables and the GHR (re-enters INIT)
//  ready_o        out  1       1 = tables initialised; predictions and updates active
//  pred_pc_i      in   word_t  fetch PC to predict
//  pred_hit_o     out  1       BTB valid and tag match for pred_pc_i
//  pred_taken_o   out  1       predict taken (pred_hit_o & counter MSB)
//  pred_target_o  out  word_t  BTB target; 0 when pred_hit_o=0
//  upd_valid_i    in   1       resolved conditional branch/jump this cycle
//  upd_pc_i       in   word_t  PC of resolved branch
//  upd_taken_i    in   1       actual outcome
//  upd_target_i   in   word_t  actual target (used only when taken)
// BEHAVIOUR
//  - Indexing: bidx = pc[IDX_W+1:2]. pidx = bidx XOR {'0, ghr[GHR_W-1:0]}; pidx = bidx when GHR_W=0.
//  - FSM: BP_INIT -> BP_RUN.
//    - BP_INIT: one entry per cycle at init_idx, 0..ENTRIES-1. Counter <= 2^(CTR_W-1)-1
//      (weakly not-taken; 0 when CTR_W=1). BTB valid <= 0.
//    - BP_INIT -> BP_RUN after writing index ENTRIES-1. ready_o rises the next cycle,
//      exactly ENTRIES cycles after rst/flush deasserts.
//  - rst: state=BP_INIT, init_idx=0, ghr=0, ready_o=0. Array contents are undefined until
//    INIT completes; no array reset.
//  - flush_i in BP_RUN: same as rst. flush_i during BP_INIT restarts init_idx at 0.
//    rst has priority over flush_i.
//  - While ready_o=0: pred_hit_o=pred_taken_o=0, pred_target_o=0, upd_valid_i ignored.
//  - Predict (0-cycle, combinational from registered arrays):
//    - hit = btb_valid[bidx] & (btb_tag[bidx]==tag(pc)).
//    - taken = hit & pht[pidx][CTR_W-1].
//  - Update (BP_RUN, upd_valid_i=1), all writes on the clock edge:
//    - pht[pidx]: +1 if taken, -1 if not, saturating at 2^CTR_W-1 and 0. No tag check;
//      aliasing is allowed.
//    - If taken: btb[bidx] <= {valid=1, tag, upd_target_i}, overwriting any entry.
//      Not-taken leaves the BTB unchanged.
//    - GHR_W>0: ghr <= {ghr[GHR_W-2:0], upd_taken_i}. pidx uses the pre-shift ghr.
//  - Same-cycle predict/update to the same index: predict sees the old contents, no bypass.
//    The new value is visible the next cycle.
//  - upd_valid_i together with flush_i: the flush wins and the update is dropped.
//  - upd_pc_i/pred_pc_i bits [1:0] are ignored.
// STRUCTURE
//  - common_types_pkg additions: typedef enum logic {BP_INIT, BP_RUN} bp_state_t;
//    parameter BP_MAX_CTR_W = 4.
//  - Module-local, width-dependent: btb_entry_t {valid, tag[TAG_W], target word_t}.
//  - One sub-module, sat_counter_next #(W): combinational saturating inc/dec
//    (ctr, up -> ctr_next). Unit-tested on its own.
//  - PHT and BTB are plain register arrays, one write port each; the init FSM and the
//    update path mux onto the write port.
// TESTING
//  1. Init: rst=1 one cycle, ENTRIES=64 -> ready_o=0 for 64 cycles, 1 on the 65th. Any pc
//     during INIT -> taken=0, hit=0, target=0.
//  2. Train: upd pc=0x100 taken target=0x240 once -> next cycle predict 0x100:
//     hit=1, taken=1 (ctr 1->2), target=0x240.
//  3. Saturation (CTR_W=2): 5 taken (ctr=3), then 1 not-taken -> still taken (ctr=2).
//     1 more not-taken -> taken=0, hit=1.
//  4. Alias: train 0x100, predict 0x200 (same bidx for ENTRIES=64, different tag)
//     -> hit=0, taken=0.
//  5. Same-cycle hazard: predict and taken-update of 0x100 in the same cycle on a fresh table
//     -> taken=0 that cycle, 1 the next.
//  6. flush_i mid-run after training -> ready_o=0 for ENTRIES cycles, then 0x100 hit=0.
//     GHR_W=4 alternating T/N at 0x100 for 32 updates -> prediction matches the pattern.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// Holds the init/run state encoding and the counter reset value helper.
package branch_predictor_pkg;

  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

  localparam int BP_MAX_CTR_W = 4;

  // Weakly not-taken: the largest value whose MSB is still clear.
  function automatic int weak_not_taken(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational saturating up/down step for a W-bit prediction counter.
// Holds at all-ones when counting up and at zero when counting down.
module sat_counter_next #(
  parameter int W = 2
) (
  input  logic [W-1:0] ctr,
  input  logic         up,
  output logic [W-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (up) begin
      if (ctr != '1) ctr_next = ctr + W'(1);
    end else begin
      if (ctr != '0) ctr_next = ctr - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: PHT of saturating counters, optional gshare
// indexing, tagged BTB, and a one-entry-per-cycle table initialisation FSM.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8,
  parameter int GHR_W   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pred_pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = TAG_W + IDX_W + 1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(weak_not_taken(CTR_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } btb_entry_t;

  logic [CTR_W-1:0] pht [ENTRIES];
  btb_entry_t       btb [ENTRIES];

  bp_state_t        state, state_next;
  logic [IDX_W-1:0] init_idx, init_idx_next;

  logic [IDX_W-1:0] pred_bidx, pred_pidx, upd_bidx, upd_pidx;
  logic [TAG_W-1:0] pred_tag, upd_tag;
  logic             upd_en;

  assign pred_bidx = pred_pc_i[IDX_W+1:2];
  assign pred_tag  = pred_pc_i[TAG_HI:TAG_LO];
  assign upd_bidx  = upd_pc_i[IDX_W+1:2];
  assign upd_tag   = upd_pc_i[TAG_HI:TAG_LO];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc_i[1:0], pred_pc_i[XLEN-1:TAG_HI+1],
                            upd_pc_i[1:0], upd_pc_i[XLEN-1:TAG_HI+1]};

  // Updates only land in RUN; a concurrent flush wins and drops them.
  assign upd_en = (state == BP_RUN) && upd_valid_i && !flush_i && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BP_INIT;
      init_idx <= '0;
    end else begin
      state    <= state_next;
      init_idx <= init_idx_next;
    end
  end

  always_comb begin
    state_next    = state;
    init_idx_next = init_idx;
    case (state)
      BP_INIT: begin
        if (flush_i) begin
          init_idx_next = '0;
        end else begin
          init_idx_next = init_idx + IDX_W'(1);
          if (init_idx == IDX_W'(ENTRIES - 1)) state_next = BP_RUN;
        end
      end
      BP_RUN: begin
        if (flush_i) begin
          state_next    = BP_INIT;
          init_idx_next = '0;
        end
      end
      default: begin
        state_next    = BP_INIT;
        init_idx_next = '0;
      end
    endcase
  end

  assign ready_o = (state == BP_RUN);

  // gshare folds the pre-shift history into the PHT index; bimodal uses bidx directly.
  generate
    if (GHR_W > 0) begin : g_gshare
      logic [GHR_W-1:0] ghr;
      always_ff @(posedge clk) begin
        if (rst || flush_i) begin
          ghr <= '0;
        end else if (upd_en) begin
          ghr <= GHR_W'({ghr, upd_taken_i});
        end
      end
      assign pred_pidx = pred_bidx ^ IDX_W'(ghr);
      assign upd_pidx  = upd_bidx ^ IDX_W'(ghr);
    end else begin : g_bimodal
      assign pred_pidx = pred_bidx;
      assign upd_pidx  = upd_bidx;
    end
  endgenerate

  btb_entry_t       pred_entry;
  logic [CTR_W-1:0] pred_ctr;
  logic             pred_hit_raw;

  assign pred_entry    = btb[pred_bidx];
  assign pred_ctr      = pht[pred_pidx];
  assign pred_hit_raw  = pred_entry.valid && (pred_entry.tag == pred_tag);
  assign pred_hit_o    = ready_o && pred_hit_raw;
  assign pred_taken_o  = pred_hit_o && pred_ctr[CTR_W-1];
  assign pred_target_o = pred_hit_o ? pred_entry.target : '0;

  logic [CTR_W-1:0] upd_ctr_next;

  sat_counter_next #(.W(CTR_W)) u_ctr_next (
    .ctr      (pht[upd_pidx]),
    .up       (upd_taken_i),
    .ctr_next (upd_ctr_next)
  );

  logic             pht_we, btb_we;
  logic [IDX_W-1:0] pht_waddr, btb_waddr;
  logic [CTR_W-1:0] pht_wdata;
  btb_entry_t       btb_wdata;

  // Single write port per table: INIT sweep owns it, otherwise the update path.
  always_comb begin
    pht_we    = 1'b0;
    pht_waddr = init_idx;
    pht_wdata = CTR_INIT;
    btb_we    = 1'b0;
    btb_waddr = init_idx;
    btb_wdata = '0;
    if (state == BP_INIT) begin
      pht_we = 1'b1;
      btb_we = 1'b1;
    end else if (upd_en) begin
      pht_we    = 1'b1;
      pht_waddr = upd_pidx;
      pht_wdata = upd_ctr_next;
      if (upd_taken_i) begin
        btb_we           = 1'b1;
        btb_waddr        = upd_bidx;
        btb_wdata.valid  = 1'b1;
        btb_wdata.tag    = upd_tag;
        btb_wdata.target = upd_target_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pht_we) pht[pht_waddr] <= pht_wdata;
    if (btb_we) btb[btb_waddr] <= btb_wdata;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: a bimodal instance and a gshare (GHR_W=4) instance,
// driven by per-cycle vectors whose expected outputs go through a scoreboard queue.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            b_flush = 1'b0, b_ready, b_hit, b_taken, b_upd_valid = 1'b0, b_upd_taken = 1'b0;
  logic [XLEN-1:0] b_pred_pc = '0, b_target, b_upd_pc = '0, b_upd_target = '0;
  logic            g_flush = 1'b0, g_ready, g_hit, g_taken, g_upd_valid = 1'b0, g_upd_taken = 1'b0;
  logic [XLEN-1:0] g_pred_pc = '0, g_target, g_upd_pc = '0, g_upd_target = '0;

  branch_predictor #(.ENTRIES(64), .CTR_W(2), .TAG_W(8), .GHR_W(0)) dut (
    .clk(clk), .rst(rst), .flush_i(b_flush), .ready_o(b_ready),
    .pred_pc_i(b_pred_pc), .pred_hit_o(b_hit), .pred_taken_o(b_taken), .pred_target_o(b_target),
    .upd_valid_i(b_upd_valid), .upd_pc_i(b_upd_pc), .upd_taken_i(b_upd_taken),
    .upd_target_i(b_upd_target)
  );

  branch_predictor #(.ENTRIES(64), .CTR_W(2), .TAG_W(8), .GHR_W(4)) dut_g (
    .clk(clk), .rst(rst), .flush_i(g_flush), .ready_o(g_ready),
    .pred_pc_i(g_pred_pc), .pred_hit_o(g_hit), .pred_taken_o(g_taken), .pred_target_o(g_target),
    .upd_valid_i(g_upd_valid), .upd_pc_i(g_upd_pc), .upd_taken_i(g_upd_taken),
    .upd_target_i(g_upd_target)
  );

  typedef struct {
    string           name;
    logic [XLEN-1:0] pred_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            flush;
    logic            exp_ready;
    logic            exp_hit;
    logic            exp_taken;
    logic [XLEN-1:0] exp_target;
  } vec_t;

  typedef struct {
    string           name;
    logic            ready;
    logic            hit;
    logic            taken;
    logic [XLEN-1:0] target;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input string n, input logic [XLEN-1:0] pc, input logic uv,
                              input logic [XLEN-1:0] upc, input logic ut,
                              input logic [XLEN-1:0] utg, input logic fl, input logic er,
                              input logic eh, input logic et, input logic [XLEN-1:0] etg);
    vec_t v;
    v.name = n; v.pred_pc = pc; v.upd_valid = uv; v.upd_pc = upc; v.upd_taken = ut;
    v.upd_target = utg; v.flush = fl; v.exp_ready = er; v.exp_hit = eh; v.exp_taken = et;
    v.exp_target = etg;
    return v;
  endfunction

  task automatic check_output(input bit use_g);
    exp_t            e;
    logic            r, h, t;
    logic [XLEN-1:0] tg;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_empty: got no expected entry, required one");
      return;
    end
    e = sb.pop_front();
    if (use_g) begin r = g_ready; h = g_hit; t = g_taken; tg = g_target; end
    else       begin r = b_ready; h = b_hit; t = b_taken; tg = b_target; end
    if ({r, h, t, tg} !== {e.ready, e.hit, e.taken, e.target}) begin
      fails++;
      $display("[TB] FAIL %s: got ready=%b hit=%b taken=%b target=%h, expected ready=%b hit=%b taken=%b target=%h",
               e.name, r, h, t, tg, e.ready, e.hit, e.taken, e.target);
    end
  endtask

  // One vector per cycle: drive, queue the expectation, sample, then step to the next negedge.
  task automatic apply_stimulus(input vec_t v, input bit use_g);
    exp_t e;
    if (use_g) begin
      g_pred_pc = v.pred_pc; g_upd_valid = v.upd_valid; g_upd_pc = v.upd_pc;
      g_upd_taken = v.upd_taken; g_upd_target = v.upd_target; g_flush = v.flush;
      b_upd_valid = 1'b0; b_flush = 1'b0;
    end else begin
      b_pred_pc = v.pred_pc; b_upd_valid = v.upd_valid; b_upd_pc = v.upd_pc;
      b_upd_taken = v.upd_taken; b_upd_target = v.upd_target; b_flush = v.flush;
      g_upd_valid = 1'b0; g_flush = 1'b0;
    end
    e.name = v.name; e.ready = v.exp_ready; e.hit = v.exp_hit;
    e.taken = v.exp_taken; e.target = v.exp_target;
    sb.push_back(e);
    #1;
    check_output(use_g);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl.push_back(mk("fresh_miss",          32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("hazard_same_cycle",   32'h100, 1, 32'h100, 1, 32'h240, 0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("train_hit",           32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 1, 1, 32'h240));
    tbl.push_back(mk("alias_tag_miss",      32'h200, 0, 32'h0,   0, 32'h0,   0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("sat_t1",              32'h100, 1, 32'h100, 1, 32'h240, 0, 1, 1, 1, 32'h240));
    tbl.push_back(mk("sat_t2",              32'h100, 1, 32'h100, 1, 32'h240, 0, 1, 1, 1, 32'h240));
    tbl.push_back(mk("sat_t3",              32'h100, 1, 32'h100, 1, 32'h240, 0, 1, 1, 1, 32'h240));
    tbl.push_back(mk("sat_n1",              32'h100, 1, 32'h100, 0, 32'h999, 0, 1, 1, 1, 32'h240));
    tbl.push_back(mk("after_n1_still_taken",32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 1, 1, 32'h240));
    tbl.push_back(mk("sat_n2",              32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 1, 1, 32'h240));
    tbl.push_back(mk("after_n2_not_taken",  32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 1, 0, 32'h240));
    tbl.push_back(mk("low_n3",              32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 1, 0, 32'h240));
    tbl.push_back(mk("low_n4_saturate",     32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 1, 0, 32'h240));
    tbl.push_back(mk("retarget_t1",         32'h100, 1, 32'h100, 1, 32'h300, 0, 1, 1, 0, 32'h240));
    tbl.push_back(mk("retarget_chk",        32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 1, 0, 32'h300));
    tbl.push_back(mk("retarget_t2",         32'h100, 1, 32'h100, 1, 32'h300, 0, 1, 1, 0, 32'h300));
    tbl.push_back(mk("low_recover",         32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 1, 1, 32'h300));
    tbl.push_back(mk("other_idx_train",     32'h104, 1, 32'h104, 1, 32'h500, 0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("other_idx_hit",       32'h104, 0, 32'h0,   0, 32'h0,   0, 1, 1, 1, 32'h500));
    tbl.push_back(mk("pc_low_bits_ignored", 32'h107, 0, 32'h0,   0, 32'h0,   0, 1, 1, 1, 32'h500));
    tbl.push_back(mk("alias_overwrite",     32'h200, 1, 32'h201, 1, 32'h600, 0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("alias_old_tag",       32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("alias_new_tag",       32'h200, 0, 32'h0,   0, 32'h0,   0, 1, 1, 1, 32'h600));
    tbl.push_back(mk("not_taken_no_btb",    32'h108, 1, 32'h108, 0, 32'h700, 0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("not_taken_chk",       32'h108, 0, 32'h0,   0, 32'h0,   0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("upper_pc_ignored",    32'h10200, 0, 32'h0, 0, 32'h0,   0, 1, 1, 1, 32'h600));
    tbl.push_back(mk("flush_with_update",   32'h200, 1, 32'h104, 0, 32'h0,   1, 1, 1, 1, 32'h600));

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Init sweep: updates presented during INIT must be ignored.
    for (int i = 0; i <= 64; i++) begin
      apply_stimulus(mk($sformatf("init_cycle_%0d", i), 32'h100 + 32'(i * 4), (i < 64),
                        32'h100, 1, 32'h240, 0, (i == 64), 0, 0, 32'h0), 0);
    end

    foreach (tbl[i]) apply_stimulus(tbl[i], 0);

    // Flush from RUN, then a second flush mid-INIT restarts the sweep.
    for (int i = 0; i <= 95; i++) begin
      apply_stimulus(mk($sformatf("flush_cycle_%0d", i), 32'h200, (i < 95), 32'h104, 1,
                        32'h800, (i == 30), (i == 95), 0, 0, 32'h0), 0);
    end
    apply_stimulus(mk("post_flush_miss_a", 32'h200, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0, 32'h0), 0);
    apply_stimulus(mk("post_flush_miss_b", 32'h104, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0, 32'h0), 0);

    // gshare: alternating T/N at one PC; history steers each outcome to its own counter.
    for (int k = 0; k < 40; k++) begin
      apply_stimulus(mk($sformatf("ghr_step_%0d", k), 32'h100, 1, 32'h100, (k % 2 == 0),
                        32'h240, 0, 1, (k > 0), (k >= 6 && k % 2 == 0),
                        (k > 0) ? 32'h240 : 32'h0), 1);
    end

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL scoreboard_leftover: got %0d pending entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
